// File: rtl/vga_pkg.sv
// Shared definitions for the parametrised VGA raster generator: pattern modes,
// stock timings and the colour-bar palette.
package vga_pkg;

   typedef enum logic [1:0] {
      MODE_FB    = 2'd0,
      MODE_SOLID = 2'd1,
      MODE_BARS  = 2'd2,
      MODE_CHECK = 2'd3
   } vga_mode_e;

   // 800x600 @ 72 Hz, 50 MHz pixel clock
   localparam int   VGA800_H_VISIBLE = 800;
   localparam int   VGA800_H_FRONT   = 56;
   localparam int   VGA800_H_SYNC    = 120;
   localparam int   VGA800_H_BACK    = 64;
   localparam int   VGA800_V_VISIBLE = 600;
   localparam int   VGA800_V_FRONT   = 37;
   localparam int   VGA800_V_SYNC    = 6;
   localparam int   VGA800_V_BACK    = 23;
   localparam logic VGA800_HS_POL    = 1'b1;
   localparam logic VGA800_VS_POL    = 1'b1;

   // 640x480 @ 60 Hz, 25.175 MHz pixel clock, negative syncs
   localparam int   VGA640_H_VISIBLE = 640;
   localparam int   VGA640_H_FRONT   = 16;
   localparam int   VGA640_H_SYNC    = 96;
   localparam int   VGA640_H_BACK    = 48;
   localparam int   VGA640_V_VISIBLE = 480;
   localparam int   VGA640_V_FRONT   = 10;
   localparam int   VGA640_V_SYNC    = 2;
   localparam int   VGA640_V_BACK    = 33;
   localparam logic VGA640_HS_POL    = 1'b0;
   localparam logic VGA640_VS_POL    = 1'b0;

   localparam logic [2:0] BAR_WHITE   = 3'b111;
   localparam logic [2:0] BAR_YELLOW  = 3'b110;
   localparam logic [2:0] BAR_CYAN    = 3'b011;
   localparam logic [2:0] BAR_GREEN   = 3'b010;
   localparam logic [2:0] BAR_MAGENTA = 3'b101;
   localparam logic [2:0] BAR_RED     = 3'b100;
   localparam logic [2:0] BAR_BLUE    = 3'b001;
   localparam logic [2:0] BAR_BLACK   = 3'b000;

   // {R,G,B} on/off per bar; index 8 covers the remainder past the last bar
   function automatic logic [2:0] bar_rgb(input logic [3:0] idx);
      case (idx)
         4'd0:    return BAR_WHITE;
         4'd1:    return BAR_YELLOW;
         4'd2:    return BAR_CYAN;
         4'd3:    return BAR_GREEN;
         4'd4:    return BAR_MAGENTA;
         4'd5:    return BAR_RED;
         4'd6:    return BAR_BLUE;
         default: return BAR_BLACK;
      endcase
   endfunction

endpackage

// File: rtl/vga_timing_pipe_pattern.sv
// Built-in test-pattern source. Colour for the current counter position is
// registered here, so it lines up with the other stage-1 signals in the top.
module vga_pattern_gen
   import vga_pkg::*;
#(
   parameter int H_VISIBLE_AREA = 800,
   parameter int WHOLE_LINE     = 1040,
   parameter int HW             = 11,
   parameter int VW             = 10,
   parameter int COLOR_BITS     = 4,
   parameter int CHECK_SHIFT    = 5
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [HW-1:0]             h_cnt,
   input  logic [VW-1:0]             v_cnt,
   input  vga_mode_e                 mode,
   input  logic [3*COLOR_BITS-1:0]   solid_color,
   output logic [3*COLOR_BITS-1:0]   pat_rgb_q
);

   localparam int BAR_W = H_VISIBLE_AREA / 8;
   localparam int BTW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

   logic [3:0]              bar_idx_q, bar_idx_d;
   logic [BTW-1:0]          bar_tmr_q, bar_tmr_d;
   logic [2:0]              bar_on;
   logic [3*COLOR_BITS-1:0] pat_d;

   // bar_idx_q/bar_tmr_q always describe the pixel h_cnt currently points at
   always_comb begin
      bar_idx_d = bar_idx_q;
      bar_tmr_d = bar_tmr_q;
      if (h_cnt == HW'(WHOLE_LINE - 1)) begin
         bar_idx_d = 4'd0;
         bar_tmr_d = BTW'(BAR_W - 1);
      end else if (bar_tmr_q == '0) begin
         bar_tmr_d = BTW'(BAR_W - 1);
         if (bar_idx_q != 4'd8) bar_idx_d = bar_idx_q + 4'd1;
      end else begin
         bar_tmr_d = bar_tmr_q - BTW'(1);
      end
   end

   assign bar_on = bar_rgb(bar_idx_q);

   always_comb begin
      pat_d = '0;
      case (mode)
         MODE_SOLID: pat_d = solid_color;
         MODE_BARS:  pat_d = {{COLOR_BITS{bar_on[2]}},
                              {COLOR_BITS{bar_on[1]}},
                              {COLOR_BITS{bar_on[0]}}};
         MODE_CHECK: begin
            if (|((32'(h_cnt) ^ 32'(v_cnt)) & (32'd1 << CHECK_SHIFT))) pat_d = '1;
         end
         default:    pat_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bar_idx_q <= 4'd0;
         bar_tmr_q <= BTW'(BAR_W - 1);
         pat_rgb_q <= '0;
      end else begin
         bar_idx_q <= bar_idx_d;
         bar_tmr_q <= bar_tmr_d;
         pat_rgb_q <= pat_d;
      end
   end

endmodule

// File: rtl/vga_timing_pipe.sv
// Parametrised VGA raster generator: stage 0 counters/decode and pixel request,
// stage 1 delayed flags plus source colour, stage 2 registered DAC pins.
module vga_timing_pipe
   import vga_pkg::*;
#(
   parameter int   H_VISIBLE_AREA = VGA800_H_VISIBLE,
   parameter int   H_FRONT_PORCH  = VGA800_H_FRONT,
   parameter int   H_SYNC_PULSE   = VGA800_H_SYNC,
   parameter int   H_BACK_PORCH   = VGA800_H_BACK,
   parameter int   V_VISIBLE_AREA = VGA800_V_VISIBLE,
   parameter int   V_FRONT_PORCH  = VGA800_V_FRONT,
   parameter int   V_SYNC_PULSE   = VGA800_V_SYNC,
   parameter int   V_BACK_PORCH   = VGA800_V_BACK,
   parameter logic HSYNC_POLARITY = VGA800_HS_POL,
   parameter logic VSYNC_POLARITY = VGA800_VS_POL,
   parameter int   COLOR_BITS     = 4,
   parameter int   CHECK_SHIFT    = 5,
   localparam int  WHOLE_LINE  = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH,
   localparam int  WHOLE_FRAME = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH,
   localparam int  HW = $clog2(WHOLE_LINE),
   localparam int  VW = $clog2(WHOLE_FRAME)
)(
   input  logic                    VGA_CLK,
   input  logic                    VGA_RST,
   input  logic [1:0]              MODE,
   input  logic [3*COLOR_BITS-1:0] SOLID_COLOR,
   output logic                    PIX_REQ,
   output logic [HW-1:0]           PIX_X,
   output logic [VW-1:0]           PIX_Y,
   input  logic [COLOR_BITS-1:0]   PIX_R,
   input  logic [COLOR_BITS-1:0]   PIX_G,
   input  logic [COLOR_BITS-1:0]   PIX_B,
   output logic                    FRAME_START,
   output logic                    LINE_START,
   output logic [COLOR_BITS-1:0]   VGA_R,
   output logic [COLOR_BITS-1:0]   VGA_G,
   output logic [COLOR_BITS-1:0]   VGA_B,
   output logic                    VGA_HS,
   output logic                    VGA_VS,
   output logic                    VGA_DE
);

   localparam int HS_START = H_VISIBLE_AREA + H_FRONT_PORCH;
   localparam int HS_END   = HS_START + H_SYNC_PULSE;
   localparam int VS_START = V_VISIBLE_AREA + V_FRONT_PORCH;
   localparam int VS_END   = VS_START + V_SYNC_PULSE;

   logic [HW-1:0]           h_cnt_q, h_cnt_d;
   logic [VW-1:0]           v_cnt_q, v_cnt_d;
   logic                    h_last, v_last;
   logic                    vis, hs_act, vs_act;
   vga_mode_e               mode_q, mode_sel;
   logic                    vis_s1_q, hs_s1_q, vs_s1_q, fb_s1_q;
   logic [3*COLOR_BITS-1:0] pat_rgb_q;
   logic [3*COLOR_BITS-1:0] rgb_q, rgb_d;
   logic                    de_q, hs_q, vs_q;

   assign h_last = (h_cnt_q == HW'(WHOLE_LINE - 1));
   assign v_last = (v_cnt_q == VW'(WHOLE_FRAME - 1));

   always_comb begin
      h_cnt_d = h_last ? '0 : h_cnt_q + HW'(1);
      v_cnt_d = v_cnt_q;
      if (h_last) v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
   end

   assign vis    = (32'(h_cnt_q) < 32'(H_VISIBLE_AREA)) && (32'(v_cnt_q) < 32'(V_VISIBLE_AREA));
   assign hs_act = (32'(h_cnt_q) >= 32'(HS_START)) && (32'(h_cnt_q) < 32'(HS_END));
   assign vs_act = (32'(v_cnt_q) >= 32'(VS_START)) && (32'(v_cnt_q) < 32'(VS_END));

   assign FRAME_START = (h_cnt_q == '0) && (v_cnt_q == '0);
   assign LINE_START  = (h_cnt_q == '0);
   assign PIX_REQ     = vis;
   assign PIX_X       = h_cnt_q;
   assign PIX_Y       = v_cnt_q;

   // MODE is used directly at (0,0) so the first pixel of a frame already sees it
   assign mode_sel = FRAME_START ? vga_mode_e'(MODE) : mode_q;

   vga_pattern_gen #(
      .H_VISIBLE_AREA (H_VISIBLE_AREA),
      .WHOLE_LINE     (WHOLE_LINE),
      .HW             (HW),
      .VW             (VW),
      .COLOR_BITS     (COLOR_BITS),
      .CHECK_SHIFT    (CHECK_SHIFT)
   ) u_pattern (
      .clk         (VGA_CLK),
      .rst         (VGA_RST),
      .h_cnt       (h_cnt_q),
      .v_cnt       (v_cnt_q),
      .mode        (mode_sel),
      .solid_color (SOLID_COLOR),
      .pat_rgb_q   (pat_rgb_q)
   );

   always_comb begin
      rgb_d = '0;
      if (vis_s1_q) rgb_d = fb_s1_q ? {PIX_R, PIX_G, PIX_B} : pat_rgb_q;
   end

   always_ff @(posedge VGA_CLK) begin
      if (VGA_RST) begin
         h_cnt_q  <= '0;
         v_cnt_q  <= '0;
         mode_q   <= MODE_FB;
         vis_s1_q <= 1'b0;
         hs_s1_q  <= 1'b0;
         vs_s1_q  <= 1'b0;
         fb_s1_q  <= 1'b0;
         rgb_q    <= '0;
         de_q     <= 1'b0;
         hs_q     <= ~HSYNC_POLARITY;
         vs_q     <= ~VSYNC_POLARITY;
      end else begin
         h_cnt_q  <= h_cnt_d;
         v_cnt_q  <= v_cnt_d;
         mode_q   <= mode_sel;
         vis_s1_q <= vis;
         hs_s1_q  <= hs_act;
         vs_s1_q  <= vs_act;
         fb_s1_q  <= (mode_sel == MODE_FB);
         rgb_q    <= rgb_d;
         de_q     <= vis_s1_q;
         hs_q     <= hs_s1_q ? HSYNC_POLARITY : ~HSYNC_POLARITY;
         vs_q     <= vs_s1_q ? VSYNC_POLARITY : ~VSYNC_POLARITY;
      end
   end

   assign VGA_R  = rgb_q[3*COLOR_BITS-1:2*COLOR_BITS];
   assign VGA_G  = rgb_q[2*COLOR_BITS-1:COLOR_BITS];
   assign VGA_B  = rgb_q[COLOR_BITS-1:0];
   assign VGA_DE = de_q;
   assign VGA_HS = hs_q;
   assign VGA_VS = vs_q;

endmodule
